// File: rtl/ddfs_sweep_ctrl.sv
// ddfs_sweep_ctrl
//   Sweep sequencer in front of the ddfs core. Steps the frequency word from
//   a start value to a stop value, holding each value for a programmable
//   dwell, so the DDFS can run unattended chirps. Waveform select and divider
//   are decoded once at launch and held for the whole sweep.
//
//   Optional feature macro: DDFS_SWEEP_BIDIR_EN
//     defined   - after reaching stop the sweep walks back to start (RETURN
//                 state). stop is not repeated; start is held once more.
//     undefined - one-way sweeps only; no RETURN state is built.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cfg_valid / cfg_ready        config handshake (ready only while idle)
//   cfg_fw_start, cfg_fw_stop    first / last frequency word
//   cfg_step                     step magnitude (0 behaves as 1)
//   cfg_dwell                    hold time per value minus 1
//   cfg_wave                     00 square, 01 sine, 10 triangle, 11 square
//   cfg_div                      ddfs freq_cntrl value
//   start, abort                 launch strobe (idle only), immediate stop
//   fw, sin, triang, freq_cntrl  registered drive of the ddfs core inputs
//   busy                         sweep in progress
//   sweep_done                   one-cycle pulse on normal completion
module ddfs_sweep_ctrl #(
  parameter int FW_WIDTH    = 7,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [FW_WIDTH-1:0]    cfg_fw_start,
  input  logic [FW_WIDTH-1:0]    cfg_fw_stop,
  input  logic [FW_WIDTH-1:0]    cfg_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [1:0]             cfg_wave,
  input  logic [2:0]             cfg_div,
  input  logic                   start,
  input  logic                   abort,
  output logic [FW_WIDTH-1:0]    fw,
  output logic                   sin,
  output logic                   triang,
  output logic [2:0]             freq_cntrl,
  output logic                   busy,
  output logic                   sweep_done
);

`ifdef DDFS_SWEEP_BIDIR_EN
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_RETURN, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_DONE} state_t;
`endif

  // One step of fw toward target, saturating at target. The extra sum bit
  // catches wrap-around in either direction so it also clamps.
  function automatic logic [FW_WIDTH-1:0] step_sat(
    input logic [FW_WIDTH-1:0] cur,
    input logic [FW_WIDTH-1:0] target,
    input logic [FW_WIDTH-1:0] stp,
    input logic                up
  );
    logic [FW_WIDTH:0]   sum;
    logic [FW_WIDTH-1:0] res;
    if (up) begin
      sum = {1'b0, cur} + {1'b0, stp};
      res = (sum[FW_WIDTH] || (sum[FW_WIDTH-1:0] > target)) ? target : sum[FW_WIDTH-1:0];
    end else begin
      sum = {1'b0, cur} - {1'b0, stp};
      res = (sum[FW_WIDTH] || (sum[FW_WIDTH-1:0] < target)) ? target : sum[FW_WIDTH-1:0];
    end
    return res;
  endfunction

  state_t                 state_q, state_d;
  logic [FW_WIDTH-1:0]    fw_q, fw_d;
  logic                   sin_q, sin_d;
  logic                   triang_q, triang_d;
  logic [2:0]             freq_cntrl_q, freq_cntrl_d;
  logic                   busy_q, busy_d;
  logic                   sweep_done_q, sweep_done_d;
  logic                   cfg_ready_q, cfg_ready_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dir_up_q, dir_up_d;
  // shadow configuration
  logic [FW_WIDTH-1:0]    sh_start_q, sh_start_d;
  logic [FW_WIDTH-1:0]    sh_stop_q, sh_stop_d;
  logic [FW_WIDTH-1:0]    sh_step_q, sh_step_d;
  logic [DWELL_WIDTH-1:0] sh_dwell_q, sh_dwell_d;
  logic [1:0]             sh_wave_q, sh_wave_d;
  logic [2:0]             sh_div_q, sh_div_d;

  logic [FW_WIDTH-1:0]    step_eff;

  always_comb begin
    state_d      = state_q;
    fw_d         = fw_q;
    sin_d        = sin_q;
    triang_d     = triang_q;
    freq_cntrl_d = freq_cntrl_q;
    busy_d       = busy_q;
    sweep_done_d = 1'b0;
    cfg_ready_d  = cfg_ready_q;
    cnt_d        = cnt_q;
    dir_up_d     = dir_up_q;
    sh_start_d   = sh_start_q;
    sh_stop_d    = sh_stop_q;
    sh_step_d    = sh_step_q;
    sh_dwell_d   = sh_dwell_q;
    sh_wave_d    = sh_wave_q;
    sh_div_d     = sh_div_q;

    step_eff = (sh_step_q == '0) ? {{(FW_WIDTH-1){1'b0}}, 1'b1} : sh_step_q;

    if (state_q == S_IDLE) begin
      if (cfg_valid) begin
        // A config word wins over a simultaneous start.
        sh_start_d = cfg_fw_start;
        sh_stop_d  = cfg_fw_stop;
        sh_step_d  = cfg_step;
        sh_dwell_d = cfg_dwell;
        sh_wave_d  = cfg_wave;
        sh_div_d   = cfg_div;
      end else if (start && !abort) begin
        fw_d         = sh_start_q;
        sin_d        = (sh_wave_q == 2'b01);
        triang_d     = (sh_wave_q == 2'b10);
        freq_cntrl_d = sh_div_q;
        cnt_d        = sh_dwell_q;
        dir_up_d     = (sh_start_q <= sh_stop_q);
        busy_d       = 1'b1;
        cfg_ready_d  = 1'b0;
        state_d      = S_DWELL;
      end
    end else if (abort) begin
      // fw and the waveform controls keep their current values.
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      cfg_ready_d = 1'b1;
    end else begin
      case (state_q)
        S_DWELL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_WIDTH'(1);
          end else if (fw_q != sh_stop_q) begin
            fw_d  = step_sat(fw_q, sh_stop_q, step_eff, dir_up_q);
            cnt_d = sh_dwell_q;
          end else begin
`ifdef DDFS_SWEEP_BIDIR_EN
            // Leaving stop steps immediately so stop is shown only once.
            if (sh_stop_q != sh_start_q) begin
              fw_d    = step_sat(fw_q, sh_start_q, step_eff, !dir_up_q);
              cnt_d   = sh_dwell_q;
              state_d = S_RETURN;
            end else begin
              sweep_done_d = 1'b1;
              state_d      = S_DONE;
            end
`else
            sweep_done_d = 1'b1;
            state_d      = S_DONE;
`endif
          end
        end
`ifdef DDFS_SWEEP_BIDIR_EN
        S_RETURN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_WIDTH'(1);
          end else if (fw_q != sh_start_q) begin
            fw_d  = step_sat(fw_q, sh_start_q, step_eff, !dir_up_q);
            cnt_d = sh_dwell_q;
          end else begin
            sweep_done_d = 1'b1;
            state_d      = S_DONE;
          end
        end
`endif
        S_DONE: begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          cfg_ready_d = 1'b1;
        end
        default: begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          cfg_ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fw_q         <= '0;
      sin_q        <= 1'b0;
      triang_q     <= 1'b0;
      freq_cntrl_q <= '0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      cfg_ready_q  <= 1'b1;
      cnt_q        <= '0;
      dir_up_q     <= 1'b0;
      sh_start_q   <= '0;
      sh_stop_q    <= '0;
      sh_step_q    <= '0;
      sh_dwell_q   <= '0;
      sh_wave_q    <= '0;
      sh_div_q     <= '0;
    end else begin
      state_q      <= state_d;
      fw_q         <= fw_d;
      sin_q        <= sin_d;
      triang_q     <= triang_d;
      freq_cntrl_q <= freq_cntrl_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      cfg_ready_q  <= cfg_ready_d;
      cnt_q        <= cnt_d;
      dir_up_q     <= dir_up_d;
      sh_start_q   <= sh_start_d;
      sh_stop_q    <= sh_stop_d;
      sh_step_q    <= sh_step_d;
      sh_dwell_q   <= sh_dwell_d;
      sh_wave_q    <= sh_wave_d;
      sh_div_q     <= sh_div_d;
    end
  end

  assign fw         = fw_q;
  assign sin        = sin_q;
  assign triang     = triang_q;
  assign freq_cntrl = freq_cntrl_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;
  assign cfg_ready  = cfg_ready_q;

endmodule
